// File: rtl/media_notas_if.sv
// Bundle of the grade-entry and display signals between the lab-board switches
// and the averaging block; clk_2 and reset stay outside as plain ports.
interface media_notas_if #(
  parameter int NBITS_NOTA = 4,
  parameter int NBITS_CNT  = 4
);
  localparam int NBITS_SOMA = NBITS_NOTA + NBITS_CNT;

  logic [NBITS_NOTA-1:0] nota_in;
  logic                  enter;
  logic                  modo;
  logic [7:0]            SEG;
  logic [NBITS_NOTA-1:0] media;
  logic [NBITS_CNT-1:0]  count;
  logic [NBITS_SOMA-1:0] soma;
  logic                  busy;
  logic                  full;

  // Entry handshake: a rising edge of enter submits nota_in, but only while
  // busy is low and full is low; any other rising edge is dropped, not queued.
  modport master (
    output nota_in, enter, modo,
    input  SEG, media, count, soma, busy, full
  );

  modport slave (
    input  nota_in, enter, modo,
    output SEG, media, count, soma, busy, full
  );
endinterface

// File: rtl/media_notas.sv
// Running sum/count of switch-entered grades, a restoring divider for the floor
// average, and an A/F/P seven-segment classifier of the grade or the average.
module media_notas #(
  parameter int          NBITS_NOTA = 4,
  parameter int          MAX_NOTAS  = 8,
  parameter int          LIM_A      = 7,
  parameter int          LIM_F      = 4,
  parameter logic [7:0]  LETRA_A    = 8'b01110111,
  parameter logic [7:0]  LETRA_F    = 8'b01110001,
  parameter logic [7:0]  LETRA_P    = 8'b01110011
) (
  input  logic         clk_2,
  input  logic         reset,
  media_notas_if.slave bus
);
  localparam int NBITS_CNT  = $clog2(MAX_NOTAS + 1);
  localparam int NBITS_SOMA = NBITS_NOTA + NBITS_CNT;
  localparam int NBITS_IT   = $clog2(NBITS_SOMA + 1);
  localparam logic [NBITS_IT-1:0]  IT_LAST  = NBITS_IT'(NBITS_SOMA - 1);
  localparam logic [NBITS_CNT-1:0] CNT_MAX  = NBITS_CNT'(MAX_NOTAS);

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t                state_q, state_nx;
  logic                  enter_q;
  logic [NBITS_SOMA-1:0] soma_q;
  logic [NBITS_CNT-1:0]  count_q;
  logic [NBITS_NOTA-1:0] media_q;
  logic [NBITS_SOMA-1:0] rem_q, quo_q, dvsr_q;
  logic [NBITS_IT-1:0]   it_q;

  logic                  req, full_w, busy_w, load, div_last;
  logic [NBITS_SOMA-1:0] soma_new;
  logic [NBITS_CNT-1:0]  count_new;
  logic [NBITS_SOMA:0]   rem_sh, dvsr_ext;
  logic                  ge;
  logic [NBITS_SOMA-1:0] rem_nx, quo_nx;
  logic [NBITS_NOTA-1:0] v;

  assign req       = bus.enter & ~enter_q;
  assign full_w    = (count_q == CNT_MAX);
  assign soma_new  = soma_q + NBITS_SOMA'(bus.nota_in);
  assign count_new = count_q + NBITS_CNT'(1);

  // State register
  always_ff @(posedge clk_2) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:  if (req && !full_w) state_nx = S_DIV;
      S_DIV:   if (it_q == IT_LAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_w   = 1'b0;
    load     = 1'b0;
    div_last = 1'b0;
    case (state_q)
      S_IDLE: load = req && !full_w;
      S_DIV: begin
        busy_w   = 1'b1;
        div_last = (it_q == IT_LAST);
      end
      default: ;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. The remainder stays below the divisor,
  // so dropping the top bit of the difference loses nothing.
  always_comb begin
    rem_sh   = {rem_q, quo_q[NBITS_SOMA-1]};
    dvsr_ext = {1'b0, dvsr_q};
    ge       = (rem_sh >= dvsr_ext);
    rem_nx   = ge ? NBITS_SOMA'(rem_sh - dvsr_ext) : rem_sh[NBITS_SOMA-1:0];
    quo_nx   = {quo_q[NBITS_SOMA-2:0], ge};
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      enter_q <= 1'b0;
      soma_q  <= '0;
      count_q <= '0;
      media_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      it_q    <= '0;
    end else begin
      enter_q <= bus.enter;
      if (load) begin
        soma_q  <= soma_new;
        count_q <= count_new;
        rem_q   <= '0;
        quo_q   <= soma_new;
        dvsr_q  <= NBITS_SOMA'(count_new);
        it_q    <= '0;
      end else if (busy_w) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        it_q  <= it_q + NBITS_IT'(1);
        // The average never exceeds the largest grade, so the low bits are exact.
        if (div_last) media_q <= quo_nx[NBITS_NOTA-1:0];
      end
    end
  end

  always_comb begin
    v = bus.modo ? media_q : bus.nota_in;
    if (int'(v) >= LIM_A)      bus.SEG = LETRA_A;
    else if (int'(v) >= LIM_F) bus.SEG = LETRA_F;
    else                       bus.SEG = LETRA_P;
  end

  assign bus.media = media_q;
  assign bus.count = count_q;
  assign bus.soma  = soma_q;
  assign bus.busy  = busy_w;
  assign bus.full  = full_w;
endmodule

// File: tb/tb_media_notas.sv
// Randomized bench for media_notas: a sum/count model with integer division
// predicts soma, count, media, SEG, busy length and the full condition.
module tb_media_notas;
  localparam int NB   = 4;
  localparam int MAXN = 8;
  localparam int CB   = 4;
  localparam int SB   = NB + CB;
  localparam logic [7:0] L_A = 8'b01110111;
  localparam logic [7:0] L_F = 8'b01110001;
  localparam logic [7:0] L_P = 8'b01110011;

  logic clk_2 = 1'b0;
  logic reset;
  always #5 clk_2 = ~clk_2;

  media_notas_if #(.NBITS_NOTA(NB), .NBITS_CNT(CB)) bus();

  media_notas #(.NBITS_NOTA(NB), .MAX_NOTAS(MAXN), .LIM_A(7), .LIM_F(4)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_sum, m_cnt, m_media;
  int bc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] letter(input int val);
    if (val >= 7)      return L_A;
    else if (val >= 4) return L_F;
    else               return L_P;
  endfunction

  task automatic tick;
    @(posedge clk_2);
    #1;
    if (bus.busy) bc++;
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    bus.enter = 1'b0;
    tick();
    tick();
    reset   = 1'b0;
    m_sum   = 0;
    m_cnt   = 0;
    m_media = 0;
    bc      = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_soma"},  32'(bus.soma),  32'(m_sum));
    chk({tag, "_count"}, 32'(bus.count), 32'(m_cnt));
    chk({tag, "_full"},  32'(bus.full),  32'(m_cnt == MAXN));
  endtask

  // Raises enter (caller keeps it low beforehand) and checks the edge it lands on.
  task automatic start_entry(input int g, output bit accepted);
    bus.nota_in = NB'(g);
    bus.enter   = 1'b1;
    bc          = 0;
    accepted    = (m_cnt < MAXN);
    if (accepted) begin
      m_sum += g;
      m_cnt += 1;
    end
    tick();
    chk("entry_busy", 32'(bus.busy), 32'(accepted));
    check_state("entry");
    if (!accepted) chk("rej_media", 32'(bus.media), 32'(m_media));
  endtask

  task automatic wait_done;
    int guard;
    logic [NB-1:0] g;
    guard = 0;
    while (bus.busy && guard < 50) begin
      tick();
      guard++;
    end
    chk("busy_timeout", 32'(guard >= 50), 32'd0);
    m_media = m_sum / m_cnt;
    chk("busy_len", 32'(bc), 32'(SB));
    chk("media", 32'(bus.media), 32'(m_media));
    check_state("done");
    bus.modo = 1'b1;
    #1;
    chk("seg_media", 32'(bus.SEG), 32'(letter(m_media)));
    bus.modo = 1'b0;
    g = NB'($urandom_range(0, 15));
    bus.nota_in = g;
    #1;
    chk("seg_nota", 32'(bus.SEG), 32'(letter(int'(g))));
  endtask

  task automatic release_enter;
    bus.enter = 1'b0;
    tick();
  endtask

  task automatic submit(input int g);
    bit acc;
    start_entry(g, acc);
    if (acc) wait_done();
    release_enter();
  endtask

  initial begin
    bit acc;
    bus.nota_in = '0;
    bus.enter   = 1'b0;
    bus.modo    = 1'b0;
    do_reset();

    // Reset state with modo=1
    bus.modo = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_media", 32'(bus.media), 32'd0);
    chk("rst_soma",  32'(bus.soma),  32'd0);
    chk("rst_seg",   32'(bus.SEG),   32'(L_P));
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_full",  32'(bus.full),  32'd0);

    // 9 then 3: average 6
    submit(9);
    submit(3);
    bus.modo = 1'b1;
    #1;
    chk("avg6_seg", 32'(bus.SEG), 32'(L_F));
    bus.modo    = 1'b0;
    bus.nota_in = 4'd2;
    #1;
    chk("nota2_seg", 32'(bus.SEG), 32'(L_P));

    // Held enter yields one entry; toggles during busy are dropped
    do_reset();
    start_entry(5, acc);
    wait_done();
    for (int i = 0; i < 12; i++) tick();
    chk("hold_count", 32'(bus.count), 32'd1);
    chk("hold_busy",  32'(bus.busy),  32'd0);
    release_enter();
    start_entry(4, acc);
    tick();
    chk("div_media_hold", 32'(bus.media), 32'd5);
    bus.enter = 1'b0;
    tick();
    bus.enter = 1'b1;
    tick();
    wait_done();
    for (int i = 0; i < 3; i++) tick();
    chk("drop_count", 32'(bus.count), 32'd2);
    release_enter();

    // Fill to MAX_NOTAS, then one more must be discarded
    do_reset();
    for (int i = 0; i < MAXN + 1; i++) submit($urandom_range(0, 15));
    chk("full_final", 32'(bus.full), 32'd1);

    // Random rounds
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0, n = $urandom_range(1, MAXN + 2); i < n; i++)
        submit($urandom_range(0, 15));
    end

    // Reset during the third cycle of a division
    do_reset();
    start_entry(15, acc);
    tick();
    tick();
    reset     = 1'b1;
    bus.enter = 1'b0;
    bus.modo  = 1'b1;
    tick();
    reset   = 1'b0;
    m_sum   = 0;
    m_cnt   = 0;
    m_media = 0;
    chk("abort_busy",  32'(bus.busy),  32'd0);
    chk("abort_media", 32'(bus.media), 32'd0);
    chk("abort_seg",   32'(bus.SEG),   32'(L_P));
    check_state("abort");
    for (int i = 0; i < SB + 2; i++) tick();
    chk("abort_media_late", 32'(bus.media), 32'd0);
    chk("abort_busy_late",  32'(bus.busy),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
